// File: rtl/cpu_step_pkg.sv
// Shared types and defaults for the CPU step controller.
// FSM state encoding, phase-index width helper and default parameter values.
package cpu_step_pkg;

    localparam int DEBOUNCE_CYC_DEF = 16;
    localparam int PHASE_N_DEF      = 5;
    localparam int PHASE_LEN_DEF    = 4;
    localparam int CNT_W_DEF        = 6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        STEP     = 2'd2,
        WAIT_REL = 2'd3
    } step_state_t;

    // Width needed to index PHASE_N phases (never less than one bit).
    function automatic int phase_idx_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/step_debounce.sv
// Button synchronizer plus stable-level counter.
// btn_stable_hi / btn_stable_lo pulse once when the synchronized button has
// held the same level for DEBOUNCE_CYC cycles since the last level change or
// since the last clr from the controller.
module step_debounce
    import cpu_step_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic clr,
    output logic btn_sync,
    output logic btn_stable_hi,
    output logic btn_stable_lo
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(DEBOUNCE_CYC);

    logic          btn_meta_r;
    logic          btn_sync_r;
    logic [CW-1:0] cnt_r;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta_r <= 1'b0;
            btn_sync_r <= 1'b0;
        end else begin
            btn_meta_r <= btn_raw;
            btn_sync_r <= btn_meta_r;
        end
    end

    // Count cycles at a stable level; saturating one past the target so the pulse fires once.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr || (btn_meta_r != btn_sync_r)) begin
            cnt_r <= {CW{1'b0}};
        end else if (cnt_r != CNT_SAT) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign btn_sync      = btn_sync_r;
    assign btn_stable_hi = btn_sync_r && (cnt_r == CNT_LAST);
    assign btn_stable_lo = !btn_sync_r && (cnt_r == CNT_LAST);

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU step controller: turns a debounced step button or a run request into
// fixed-length multi-phase steps (cpu_clk_en + one-hot phase strobes) and
// counts completed steps.
// Optional macro STEP_BREAK_EN adds a step-count breakpoint for run mode
// (ports bp_en, bp_count, bp_hit).
module cpu_step_ctrl
    import cpu_step_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int PHASE_N      = PHASE_N_DEF,
    parameter int PHASE_LEN    = PHASE_LEN_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_btn,
    input  logic               run_mode,
    input  logic               halt,
`ifdef STEP_BREAK_EN
    input  logic               bp_en,
    input  logic [CNT_W-1:0]   bp_count,
    output logic               bp_hit,
`endif
    output logic [PHASE_N-1:0] phase_stb,
    output logic               cpu_clk_en,
    output logic               busy,
    output logic [CNT_W-1:0]   step_count
);

    localparam int PW = phase_idx_w(PHASE_N);
    localparam int LW = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PHASE_N - 1);
    localparam logic [LW-1:0] L_LAST = LW'(PHASE_LEN - 1);

    step_state_t        state_r;
    step_state_t        state_next_s;
    logic [PW-1:0]      phase_r;
    logic [PW-1:0]      phase_next_s;
    logic [LW-1:0]      len_r;
    logic [LW-1:0]      len_next_s;
    logic               step_end_s;
    logic               step_start_s;
    logic               dbn_clr_s;
    logic               bp_match_s;
    logic               bp_block_s;
    logic [CNT_W-1:0]   count_inc_s;
    logic               btn_sync_s;
    logic               btn_hi_s;
    logic               btn_lo_s;
    logic [PHASE_N-1:0] phase_stb_r;
    logic               cpu_clk_en_r;
    logic               busy_r;
    logic [CNT_W-1:0]   step_count_r;

    step_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (step_btn),
        .clr           (dbn_clr_s),
        .btn_sync      (btn_sync_s),
        .btn_stable_hi (btn_hi_s),
        .btn_stable_lo (btn_lo_s)
    );

    assign count_inc_s = step_count_r + {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef STEP_BREAK_EN
    logic bp_stop_r;
    logic bp_hit_r;

    assign bp_match_s = bp_en && (count_inc_s == bp_count);
    assign bp_block_s = bp_stop_r;
    assign bp_hit     = bp_hit_r;

    // Breakpoint pulse, plus a sticky stop that keeps run mode parked until run/bp is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            bp_hit_r  <= 1'b0;
            bp_stop_r <= 1'b0;
        end else begin
            bp_hit_r <= step_end_s && run_mode && bp_match_s;
            if (!run_mode || !bp_en) begin
                bp_stop_r <= 1'b0;
            end else if (step_end_s && bp_match_s) begin
                bp_stop_r <= 1'b1;
            end else begin
                bp_stop_r <= bp_stop_r;
            end
        end
    end
`else
    assign bp_match_s = 1'b0;
    assign bp_block_s = 1'b0;
`endif

    // Next-state, phase/length counters and debounce-clear decisions.
    always_comb begin
        state_next_s = state_r;
        phase_next_s = phase_r;
        len_next_s   = len_r;
        step_start_s = 1'b0;
        dbn_clr_s    = 1'b0;
        step_end_s   = (state_r == STEP) && (phase_r == P_LAST) && (len_r == L_LAST);
        case (state_r)
            IDLE: begin
                if (run_mode && !halt && !bp_block_s) begin
                    state_next_s = STEP;
                    step_start_s = 1'b1;
                end else if (btn_sync_s && !run_mode && !halt) begin
                    state_next_s = DEBOUNCE;
                    dbn_clr_s    = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DEBOUNCE: begin
                if (!btn_sync_s) begin
                    state_next_s = IDLE;
                end else if (btn_hi_s) begin
                    state_next_s = STEP;
                    step_start_s = 1'b1;
                end else begin
                    state_next_s = DEBOUNCE;
                end
            end
            STEP: begin
                if (step_end_s) begin
                    // A single step always waits for release, so a held button never repeats.
                    if (!run_mode) begin
                        state_next_s = WAIT_REL;
                        dbn_clr_s    = 1'b1;
                    end else if (halt || bp_match_s) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = STEP;
                        step_start_s = 1'b1;
                    end
                end else if (len_r == L_LAST) begin
                    len_next_s   = {LW{1'b0}};
                    phase_next_s = phase_r + {{(PW-1){1'b0}}, 1'b1};
                end else begin
                    len_next_s   = len_r + {{(LW-1){1'b0}}, 1'b1};
                end
            end
            WAIT_REL: begin
                if (btn_lo_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_REL;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        if (step_start_s || (state_next_s != STEP)) begin
            phase_next_s = {PW{1'b0}};
            len_next_s   = {LW{1'b0}};
        end else begin
            phase_next_s = phase_next_s;
            len_next_s   = len_next_s;
        end
    end

    // State register and registered strobes, derived from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            phase_r      <= {PW{1'b0}};
            len_r        <= {LW{1'b0}};
            phase_stb_r  <= {PHASE_N{1'b0}};
            cpu_clk_en_r <= 1'b0;
            busy_r       <= 1'b0;
            step_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_next_s;
            phase_r      <= phase_next_s;
            len_r        <= len_next_s;
            cpu_clk_en_r <= step_start_s;
            busy_r       <= (state_next_s == STEP);
            if ((state_next_s == STEP) && (len_next_s == {LW{1'b0}})) begin
                phase_stb_r <= {{(PHASE_N-1){1'b0}}, 1'b1} << phase_next_s;
            end else begin
                phase_stb_r <= {PHASE_N{1'b0}};
            end
            if (step_end_s) begin
                step_count_r <= count_inc_s;
            end else begin
                step_count_r <= step_count_r;
            end
        end
    end

    assign phase_stb  = phase_stb_r;
    assign cpu_clk_en = cpu_clk_en_r;
    assign busy       = busy_r;
    assign step_count = step_count_r;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed self-checking bench for cpu_step_ctrl (default parameters).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cpu_step_ctrl;
    import cpu_step_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       step_btn;
    logic       run_mode;
    logic       halt;
    logic [4:0] phase_stb;
    logic       cpu_clk_en;
    logic       busy;
    logic [5:0] step_count;
`ifdef STEP_BREAK_EN
    logic       bp_en;
    logic [5:0] bp_count;
    logic       bp_hit;
`endif

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;
    int en_cnt, busy_cnt, stb_cnt, bp_cnt;
    int en_cyc[$];
    int stb_first[5];
    int start_c;

    cpu_step_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .step_btn   (step_btn),
        .run_mode   (run_mode),
        .halt       (halt),
`ifdef STEP_BREAK_EN
        .bp_en      (bp_en),
        .bp_count   (bp_count),
        .bp_hit     (bp_hit),
`endif
        .phase_stb  (phase_stb),
        .cpu_clk_en (cpu_clk_en),
        .busy       (busy),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_rec();
        en_cnt = 0; busy_cnt = 0; stb_cnt = 0; bp_cnt = 0;
        en_cyc.delete();
        for (int i = 0; i < 5; i++) stb_first[i] = -1000;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            if (cpu_clk_en === 1'b1) begin
                en_cnt++;
                en_cyc.push_back(cyc);
            end
            if (busy === 1'b1) busy_cnt++;
            for (int i = 0; i < 5; i++) begin
                if (phase_stb[i] === 1'b1) begin
                    stb_cnt++;
                    if (stb_first[i] < 0) stb_first[i] = cyc;
                end
            end
`ifdef STEP_BREAK_EN
            if (bp_hit === 1'b1) bp_cnt++;
`endif
        end
    endtask

    function automatic int en_at(input int k);
        if (en_cyc.size() > k) return en_cyc[k];
        else return -1000;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        ticks(3);
        rst = 1'b0;
        clear_rec();
    endtask

    initial begin
        rst = 1'b1; step_btn = 1'b0; run_mode = 1'b0; halt = 1'b0;
`ifdef STEP_BREAK_EN
        bp_en = 1'b0; bp_count = 6'd0;
`endif
        clear_rec();

        // Reset state
        do_reset();
        ticks(1);
        check("rst_clk_en", int'(cpu_clk_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_phase_stb", int'(phase_stb), 0);
        check("rst_step_count", int'(step_count), 0);
        check("rst_state", int'(dut.state_r), int'(IDLE));

        // Clean press held 100 cycles, single-step
        clear_rec();
        start_c = cyc;
        step_btn = 1'b1;
        ticks(100);
        step_btn = 1'b0;
        ticks(40);
        check("press_en_cnt", en_cnt, 1);
        check("press_en_latency", en_at(0) - start_c, 19);
        for (int i = 0; i < 5; i++) check($sformatf("press_stb%0d_ofs", i), stb_first[i] - en_at(0), 4 * i);
        check("press_stb_cnt", stb_cnt, 5);
        check("press_busy_len", busy_cnt, 20);
        check("press_count", int'(step_count), 1);
        check("press_state_idle", int'(dut.state_r), int'(IDLE));

        // Bouncy press then bouncy release
        do_reset();
        for (int i = 0; i < 30; i++) begin
            step_btn = ((i / 3) % 2 == 0);
            ticks(1);
        end
        start_c = cyc;
        step_btn = 1'b1;
        ticks(70);
        for (int i = 0; i < 30; i++) begin
            step_btn = ((i / 3) % 2 == 1);
            ticks(1);
        end
        step_btn = 1'b0;
        ticks(40);
        check("bounce_en_cnt", en_cnt, 1);
        check("bounce_en_latency", en_at(0) - start_c, 19);
        check("bounce_count", int'(step_count), 1);
        check("bounce_state_idle", int'(dut.state_r), int'(IDLE));

        // Halt blocks a press
        clear_rec();
        halt = 1'b1;
        step_btn = 1'b1;
        ticks(40);
        step_btn = 1'b0;
        halt = 1'b0;
        ticks(5);
        check("halt_press_en_cnt", en_cnt, 0);
        check("halt_press_count", int'(step_count), 1);

        // Run mode with halt raised mid third step
        do_reset();
        start_c = cyc;
        run_mode = 1'b1;
        ticks(51);
        halt = 1'b1;
        ticks(11);
        check("run_idle_by_61", int'(dut.state_r), int'(IDLE));
        check("run_busy_low", int'(busy), 0);
        ticks(38);
        run_mode = 1'b0;
        halt = 1'b0;
        ticks(5);
        check("run_en_cnt", en_cnt, 3);
        for (int k = 0; k < 3; k++) check($sformatf("run_en%0d_cyc", k), en_at(k) - start_c, 1 + 20 * k);
        check("run_busy_len", busy_cnt, 60);
        check("run_count", int'(step_count), 3);

        // Counter wrap after 64 run steps
        do_reset();
        start_c = cyc;
        run_mode = 1'b1;
        ticks(1265);
        check("wrap_count_63", int'(step_count), 63);
        ticks(5);
        halt = 1'b1;
        ticks(15);
        check("wrap_count_0", int'(step_count), 0);
        check("wrap_en_cnt", en_cnt, 64);
        check("wrap_busy_low", int'(busy), 0);
        check("wrap_state_idle", int'(dut.state_r), int'(IDLE));
        run_mode = 1'b0;
        halt = 1'b0;
        ticks(3);

`ifdef STEP_BREAK_EN
        // Breakpoint at step 5 in run mode
        do_reset();
        bp_en = 1'b1;
        bp_count = 6'd5;
        run_mode = 1'b1;
        ticks(150);
        check("bp_en_cnt", en_cnt, 5);
        check("bp_count", int'(step_count), 5);
        check("bp_hit_cnt", bp_cnt, 1);
        check("bp_state_idle", int'(dut.state_r), int'(IDLE));
        run_mode = 1'b0;
        bp_en = 1'b0;
        ticks(3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
